// File: rtl/csr_exec_unit.sv
// Zicsr execution stage: reads the addressed CSR, computes the new value, drives
// the csr_file write port and returns the old value. Owns the cycle/instret counters.
module csr_exec_unit #(
  parameter bit          COUNTERS_EN = 1'b1,
  parameter logic [63:0] RESET_CYCLE = 64'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [11:0] req_csr_addr,
  input  logic [31:0] req_rs1_val,
  input  logic [4:0]  req_src_idx,
  input  logic [4:0]  req_rd,
  input  logic        retire,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [4:0]  resp_rd,
  output logic [31:0] resp_data,
  output logic        resp_illegal,
  output logic        csr_wr,
  output logic [11:0] csr_wrAddr,
  output logic [31:0] csr_wrVal,
  output logic [11:0] csr_rdAddr,
  input  logic [31:0] csr_rdVal
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state;
  logic [2:0]  funct3Q;
  logic [11:0] addrQ;
  logic [31:0] rs1Q;
  logic [4:0]  srcQ;
  logic [4:0]  rdQ;
  logic [63:0] cycleCnt;
  logic [63:0] instretCnt;

  logic        isCounter;
  logic [63:0] ctrWord;
  logic [31:0] oldVal;
  logic [31:0] operand;
  logic [31:0] newVal;
  logic        wrEn;
  logic        illegal;
  logic        ctrWrite;
  logic        fileWrite;

  always_comb begin
    // Matches B00/B80/B02/B82 and their read-only C-space aliases.
    isCounter = ((addrQ[11:8] == 4'hB) || (addrQ[11:8] == 4'hC)) &&
                (addrQ[6:2] == 5'd0) && !addrQ[0];
    ctrWord   = addrQ[1] ? instretCnt : cycleCnt;
    if (isCounter)
      oldVal = COUNTERS_EN ? (addrQ[7] ? ctrWord[63:32] : ctrWord[31:0]) : 32'd0;
    else
      oldVal = csr_rdVal;
    operand = funct3Q[2] ? {27'd0, srcQ} : rs1Q;
    case (funct3Q[1:0])
      2'b01:   newVal = operand;
      2'b10:   newVal = oldVal | operand;
      2'b11:   newVal = oldVal & ~operand;
      default: newVal = operand;
    endcase
    wrEn      = (funct3Q[1:0] == 2'b01) || (srcQ != 5'd0);
    illegal   = (funct3Q[1:0] == 2'b00) || (wrEn && (addrQ[11:10] == 2'b11));
    ctrWrite  = (state == EXEC) && !illegal && wrEn && isCounter && COUNTERS_EN;
    fileWrite = !illegal && wrEn && !isCounter;
  end

  // A counter write replaces one half and suppresses that edge's increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycleCnt   <= RESET_CYCLE;
      instretCnt <= 64'd0;
    end else begin
      if (ctrWrite && !addrQ[1])
        cycleCnt <= addrQ[7] ? {newVal, cycleCnt[31:0]} : {cycleCnt[63:32], newVal};
      else
        cycleCnt <= cycleCnt + 64'd1;
      if (ctrWrite && addrQ[1])
        instretCnt <= addrQ[7] ? {newVal, instretCnt[31:0]} : {instretCnt[63:32], newVal};
      else if (retire)
        instretCnt <= instretCnt + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      funct3Q      <= 3'd0;
      addrQ        <= 12'd0;
      rs1Q         <= 32'd0;
      srcQ         <= 5'd0;
      rdQ          <= 5'd0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_illegal <= 1'b0;
      resp_data    <= 32'd0;
      resp_rd      <= 5'd0;
      csr_wr       <= 1'b0;
      csr_wrAddr   <= 12'd0;
      csr_wrVal    <= 32'd0;
      csr_rdAddr   <= 12'd0;
    end else begin
      case (state)
        IDLE: begin
          csr_wr <= 1'b0;
          if (req_valid) begin
            funct3Q    <= req_funct3;
            addrQ      <= req_csr_addr;
            rs1Q       <= req_rs1_val;
            srcQ       <= req_src_idx;
            rdQ        <= req_rd;
            csr_rdAddr <= req_csr_addr;
            req_ready  <= 1'b0;
            state      <= EXEC;
          end
        end
        EXEC: begin
          csr_wr <= fileWrite;
          if (fileWrite) begin
            csr_wrAddr <= addrQ;
            csr_wrVal  <= newVal;
          end
          resp_data    <= illegal ? 32'd0 : oldVal;
          resp_illegal <= illegal;
          resp_rd      <= rdQ;
          state        <= RESP;
        end
        RESP: begin
          csr_wr <= 1'b0;
          if (!resp_valid) begin
            resp_valid <= 1'b1;
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          csr_wr    <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_exec_unit.sv
// Scoreboard bench for csr_exec_unit: a driver issues Zicsr requests and queues the
// responses and csr_file writes predicted by a reference model; a monitor checks them.
module tb_csr_exec_unit;

  localparam logic [63:0] RC = 64'd0;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid, req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_csr_addr;
  logic [31:0] req_rs1_val;
  logic [4:0]  req_src_idx, req_rd;
  logic        retire;
  logic        resp_valid, resp_ready;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic        resp_illegal;
  logic        csr_wr;
  logic [11:0] csr_wrAddr, csr_rdAddr;
  logic [31:0] csr_wrVal, csr_rdVal;

  csr_exec_unit #(.COUNTERS_EN(1'b1), .RESET_CYCLE(RC)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_csr_addr(req_csr_addr), .req_rs1_val(req_rs1_val),
    .req_src_idx(req_src_idx), .req_rd(req_rd), .retire(retire),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rd(resp_rd),
    .resp_data(resp_data), .resp_illegal(resp_illegal),
    .csr_wr(csr_wr), .csr_wrAddr(csr_wrAddr), .csr_wrVal(csr_wrVal),
    .csr_rdAddr(csr_rdAddr), .csr_rdVal(csr_rdVal)
  );

  always #5 clk = ~clk;

  // csr_file stand-in (driven only by the DUT) and the reference copy of its contents
  logic [31:0] fileMem [4096];
  logic [31:0] refMem  [4096];
  assign csr_rdVal = fileMem[csr_rdAddr];
  always @(posedge clk) if (csr_wr) fileMem[csr_wrAddr] = csr_wrVal;

  int tbCycle = 0;
  always @(posedge clk) tbCycle++;

  // Reference counters; the driver posts counter writes to land on the EXEC edge
  logic [63:0] mCyc = RC, mIns = 64'd0;
  bit          pendCyc = 0, pendIns = 0, pendHigh = 0;
  logic [31:0] pendVal = 32'd0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mCyc = RC; mIns = 64'd0; pendCyc = 0; pendIns = 0;
    end else begin
      if (pendCyc) begin
        if (pendHigh) mCyc[63:32] = pendVal; else mCyc[31:0] = pendVal;
      end else mCyc = mCyc + 64'd1;
      if (pendIns) begin
        if (pendHigh) mIns[63:32] = pendVal; else mIns[31:0] = pendVal;
      end else if (retire) mIns = mIns + 64'd1;
      pendCyc = 0; pendIns = 0;
    end
  end

  typedef struct { logic [4:0] rd; logic [31:0] data; logic ill; } resp_t;
  typedef struct { logic [11:0] addr; logic [31:0] val; int cyc; } wr_t;
  resp_t respQ[$];
  wr_t   wrQ[$];
  int    latQ[$];

  int nChecks = 0, nFail = 0;
  bit holdReady = 0, rndRetire = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic bit isCtr(input logic [11:0] a);
    return a inside {12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82};
  endfunction
  function automatic bit isIns(input logic [11:0] a);
    return a inside {12'hB02, 12'hB82, 12'hC02, 12'hC82};
  endfunction
  function automatic bit isHigh(input logic [11:0] a);
    return a inside {12'hB80, 12'hB82, 12'hC80, 12'hC82};
  endfunction
  function automatic logic [31:0] ctrRead(input logic [11:0] a);
    logic [63:0] v;
    v = isIns(a) ? mIns : mCyc;
    return isHigh(a) ? v[63:32] : v[31:0];
  endfunction

  initial begin
    resp_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      resp_ready = holdReady ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor
  initial begin
    logic pv, pr;
    logic [31:0] pd;
    pv = 0; pr = 0; pd = 0;
    forever begin
      @(negedge clk);
      if (csr_wr) begin
        if (wrQ.size() == 0) chk("unexpected_csr_wr", 1, 0);
        else begin
          wr_t w;
          w = wrQ.pop_front();
          chk("wr_addr", csr_wrAddr, w.addr);
          chk("wr_val", csr_wrVal, w.val);
          chk("wr_timing", 64'(tbCycle), 64'(w.cyc));
        end
      end
      if (!reset_n) begin
        pv = 0; pr = 0;
      end else begin
        if (resp_valid) chk("req_ready_low_in_resp", req_ready, 0);
        if (resp_valid && !pv) begin
          if (latQ.size() == 0) chk("unexpected_resp_valid", 1, 0);
          else chk("resp_latency", 64'(tbCycle), 64'(latQ.pop_front() + 2));
        end
        if (pv && !pr) begin
          chk("resp_held_valid", resp_valid, 1);
          chk("resp_data_stable", resp_data, pd);
        end
        if (resp_valid && resp_ready) begin
          if (respQ.size() == 0) chk("unexpected_resp", 1, 0);
          else begin
            resp_t r;
            r = respQ.pop_front();
            $display("txn rd=%0d data=%08h illegal=%0b", resp_rd, resp_data, resp_illegal);
            chk("resp_rd", resp_rd, r.rd);
            chk("resp_data", resp_data, r.data);
            chk("resp_illegal", resp_illegal, r.ill);
          end
        end
        pv = resp_valid; pr = resp_ready; pd = resp_data;
      end
    end
  end

  task automatic waitReady();
    int t = 0;
    while (!req_ready && t < 100) begin @(negedge clk); t++; end
    chk("req_ready_idle", req_ready, 1);
  endtask

  task automatic doCsr(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] rs1,
                       input logic [4:0] src, input logic [4:0] rd, input bit retExec, input bit hold);
    int t;
    logic [31:0] old, opnd, nv;
    bit wen, ill;
    resp_t r;
    wr_t w;
    waitReady();
    holdReady = hold;
    req_funct3 = f3; req_csr_addr = addr; req_rs1_val = rs1; req_src_idx = src; req_rd = rd;
    req_valid = 1'b1;
    retire = rndRetire ? 1'($urandom_range(0, 1)) : 1'b0;
    @(negedge clk);
    old  = isCtr(addr) ? ctrRead(addr) : refMem[addr];
    opnd = f3[2] ? {27'd0, src} : rs1;
    case (f3[1:0])
      2'b01:   nv = opnd;
      2'b10:   nv = old | opnd;
      2'b11:   nv = old & ~opnd;
      default: nv = 32'd0;
    endcase
    wen = (f3[1:0] == 2'b01) || (src != 5'd0);
    ill = (f3[1:0] == 2'b00) || (wen && addr >= 12'hC00);
    r.rd = rd; r.data = ill ? 32'd0 : old; r.ill = ill;
    respQ.push_back(r);
    latQ.push_back(tbCycle);
    if (!ill && wen) begin
      if (isCtr(addr)) begin
        pendCyc = !isIns(addr); pendIns = isIns(addr); pendHigh = isHigh(addr); pendVal = nv;
      end else begin
        refMem[addr] = nv;
        w.addr = addr; w.val = nv; w.cyc = tbCycle + 1;
        wrQ.push_back(w);
      end
    end
    retire = retExec | (rndRetire ? 1'($urandom_range(0, 1)) : 1'b0);
    if (!hold) req_valid = 1'b0;
    @(negedge clk);
    retire = rndRetire ? 1'($urandom_range(0, 1)) : 1'b0;
    if (hold) begin
      t = 0;
      while (!resp_valid && t < 10) begin @(negedge clk); t++; end
      repeat (5) @(negedge clk);
      holdReady = 0;
      t = 0;
      while (resp_valid && t < 50) begin @(negedge clk); t++; end
      chk("hold_handshake_done", resp_valid, 0);
      req_valid = 1'b0;
    end
  endtask

  task automatic pulses(input int n);
    repeat (n) begin retire = 1'b1; @(negedge clk); end
    retire = 1'b0;
  endtask

  logic [11:0] addrs [12] = '{12'h340, 12'h341, 12'h305, 12'h300, 12'hC00, 12'hC80,
                              12'hC02, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF11};

  initial begin
    int t;
    logic [31:0] v;
    for (int i = 0; i < 4096; i++) begin v = $urandom; fileMem[i] = v; refMem[i] = v; end
    fileMem[12'h340] = 32'h12345678; refMem[12'h340] = 32'h12345678;
    req_valid = 0; req_funct3 = 0; req_csr_addr = 0; req_rs1_val = 0;
    req_src_idx = 0; req_rd = 0; retire = 0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_illegal", resp_illegal, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_rd", resp_rd, 0);
    chk("rst_csr_wr", csr_wr, 0);
    chk("rst_csr_wrAddr", csr_wrAddr, 0);
    chk("rst_csr_wrVal", csr_wrVal, 0);
    chk("rst_csr_rdAddr", csr_rdAddr, 0);
    reset_n = 1'b1;
    @(negedge clk);

    doCsr(3'b001, 12'h340, 32'hDEADBEEF, 5'd1, 5'd3, 0, 0);  // CSRRW
    doCsr(3'b010, 12'h340, $urandom,     5'd0, 5'd4, 0, 0);  // CSRRS, no write
    doCsr(3'b001, 12'h340, 32'hFFFFFFFF, 5'd2, 5'd5, 0, 0);
    doCsr(3'b111, 12'h340, $urandom,     5'h0F, 5'd6, 0, 0); // CSRRCI -> FFFFFFF0
    doCsr(3'b010, 12'h340, 32'd0,        5'd0, 5'd7, 0, 0);
    doCsr(3'b001, 12'hC00, $urandom,     5'd1, 5'd8, 0, 0);  // read-only: illegal
    doCsr(3'b010, 12'hC00, $urandom,     5'd0, 5'd9, 0, 0);
    doCsr(3'b000, 12'h340, $urandom,     5'd3, 5'd10, 0, 0); // reserved funct3
    doCsr(3'b001, 12'hB02, 32'hFFFFFFFF, 5'd1, 5'd11, 0, 0);
    doCsr(3'b001, 12'hB82, 32'hFFFFFFFF, 5'd1, 5'd12, 0, 0);
    pulses(2);
    doCsr(3'b010, 12'hC02, 32'd0, 5'd0, 5'd13, 0, 0);        // wrapped to 1
    doCsr(3'b010, 12'hC82, 32'd0, 5'd0, 5'd14, 0, 0);
    doCsr(3'b001, 12'hB02, 32'h55, 5'd1, 5'd15, 1, 0);       // write beats retire
    doCsr(3'b010, 12'hC02, 32'd0, 5'd0, 5'd16, 0, 0);
    doCsr(3'b001, 12'hB80, 32'h1, 5'd1, 5'd17, 0, 0);
    doCsr(3'b010, 12'hC80, 32'd0, 5'd0, 5'd18, 0, 0);
    doCsr(3'b001, 12'h341, $urandom, 5'd1, 5'd19, 0, 1);     // held response

    // Reset while the instruction sits in EXEC
    waitReady();
    req_funct3 = 3'b001; req_csr_addr = 12'h340; req_rs1_val = 32'hAAAA5555;
    req_src_idx = 5'd1; req_rd = 5'd20; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; reset_n = 1'b0;
    @(negedge clk);
    chk("exec_rst_csr_wr", csr_wr, 0);
    chk("exec_rst_resp_valid", resp_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", req_ready, 1);
    chk("post_rst_resp_valid", resp_valid, 0);
    doCsr(3'b010, 12'hB00, 32'd0, 5'd0, 5'd21, 0, 0);
    doCsr(3'b010, 12'hB80, 32'd0, 5'd0, 5'd22, 0, 0);
    doCsr(3'b010, 12'hC02, 32'd0, 5'd0, 5'd23, 0, 0);
    doCsr(3'b010, 12'h340, 32'd0, 5'd0, 5'd24, 0, 0);        // untouched by aborted write

    rndRetire = 1;
    for (int i = 0; i < 60; i++) begin
      logic [11:0] a;
      logic [4:0]  s;
      a = addrs[$urandom_range(0, 11)];
      s = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      doCsr(3'($urandom_range(0, 7)), a, $urandom, s, 5'($urandom_range(0, 31)), 0, 0);
    end
    rndRetire = 0;
    retire = 1'b0;

    t = 0;
    while (respQ.size() != 0 && t < 200) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    chk("resp_queue_drained", 64'(respQ.size()), 0);
    chk("wr_queue_drained", 64'(wrQ.size()), 0);
    chk("lat_queue_drained", 64'(latQ.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
